// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified memory arbiter: FSM encoding and
// default RAM latency.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_INST = 2'b10
    } arbState_t;

    localparam int DefMemLatency = 2;
    localparam int CntW          = 4;

endpackage

// File: rtl/unified_mem_arbiter_counter.sv
// Down-counter that tracks cycles remaining on the outstanding RAM access.
// Loads on grant, counts to zero and rests there.
module mem_latency_counter
    import unified_mem_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [CntW-1:0] value,
    output logic [CntW-1:0] count,
    output logic            zero
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the single-ported unified RAM between instruction fetch and
// the load/store stage, and stalls the loser until its access completes.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = DefMemLatency
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [CntW-1:0] LatVal = CntW'(MEM_LATENCY);

    arbState_t         state;
    arbState_t         nextState;
    logic [CntW-1:0]   cnt;
    logic              cntZero;
    logic              cntLoad;
    logic              isStoreQ;
    logic              abortQ;
    logic [ADDR_W-1:0] ramAddrQ;
    logic [DATA_W-1:0] ramWdataQ;
    logic [DATA_W-1:0] ifRdataQ;
    logic [DATA_W-1:0] memRdataQ;

    logic busy;
    logic dataComplete;
    logic instComplete;
    logic ifDone;
    logic loadDone;
    logic dataReq;
    logic instReq;
    logic select;
    logic grantData;
    logic grantInst;

    mem_latency_counter uLatCnt (
        .clk   (clk),
        .reset (reset),
        .load  (cntLoad),
        .value (LatVal),
        .count (cnt),
        .zero  (cntZero)
    );

    assign busy         = (state != ST_IDLE);
    assign dataComplete = (state == ST_DATA) & cntZero;
    assign instComplete = (state == ST_INST) & cntZero;

    // A flushed fetch still finishes on the RAM side but is not reported.
    assign ifDone   = instComplete & if_req & ~abortQ;
    assign loadDone = dataComplete & ~isStoreQ;

    // The request being retired this cycle must not win the next grant.
    assign dataReq = (mem_rd | mem_wr) & ~dataComplete;
    assign instReq = if_req & ~ifDone;
    assign select  = (state == ST_IDLE) | dataComplete | instComplete;

    always_comb begin
        nextState = state;
        grantData = 1'b0;
        grantInst = 1'b0;
        if (select) begin
            if (dataReq) begin
                nextState = ST_DATA;
                grantData = 1'b1;
            end else if (instReq) begin
                nextState = ST_INST;
                grantInst = 1'b1;
            end else begin
                nextState = ST_IDLE;
            end
        end
    end

    assign cntLoad = grantData | grantInst;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            isStoreQ  <= 1'b0;
            abortQ    <= 1'b0;
            ramAddrQ  <= '0;
            ramWdataQ <= '0;
            ifRdataQ  <= '0;
            memRdataQ <= '0;
        end else begin
            state <= nextState;
            if (grantData) begin
                ramAddrQ <= mem_addr;
                isStoreQ <= mem_wr;
                if (mem_wr) begin
                    ramWdataQ <= mem_wdata;
                end
            end else if (grantInst) begin
                ramAddrQ <= if_addr;
                isStoreQ <= 1'b0;
            end
            if (cntLoad) begin
                abortQ <= 1'b0;
            end else if ((state == ST_INST) && !if_req) begin
                abortQ <= 1'b1;
            end
            if (ifDone) begin
                ifRdataQ <= ram_rdata;
            end
            if (loadDone) begin
                memRdataQ <= ram_rdata;
            end
        end
    end

    // The issue cycle is the only busy cycle with the counter still full.
    assign ram_en    = busy & (cnt == LatVal);
    assign ram_we    = ram_en & isStoreQ;
    assign ram_addr  = ramAddrQ;
    assign ram_wdata = ramWdataQ;

    assign if_done   = ifDone;
    assign mem_done  = dataComplete;
    assign if_rdata  = ifDone ? ram_rdata : ifRdataQ;
    assign mem_rdata = loadDone ? ram_rdata : memRdataQ;

    assign stall_if  = if_req & ~ifDone;
    assign stall_mem = (mem_rd | mem_wr) & ~dataComplete;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: per-cycle vector table on an
// L=2 instance, plus reset-abort and L=3 sequences.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset2;
    logic        reset3;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    logic [31:0] if_rdata2, mem_rdata2, ram_addr2, ram_wdata2, ram_rdata2;
    logic        if_done2, mem_done2, stall_if2, stall_mem2, ram_en2, ram_we2;
    logic [31:0] if_rdata3, mem_rdata3, ram_addr3, ram_wdata3, ram_rdata3;
    logic        if_done3, mem_done3, stall_if3, stall_mem3, ram_en3, ram_we3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.MEM_LATENCY(2)) dut2 (
        .clk       (clk),
        .reset     (reset2),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata2),
        .if_done   (if_done2),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata2),
        .mem_done  (mem_done2),
        .stall_if  (stall_if2),
        .stall_mem (stall_mem2),
        .ram_en    (ram_en2),
        .ram_we    (ram_we2),
        .ram_addr  (ram_addr2),
        .ram_wdata (ram_wdata2),
        .ram_rdata (ram_rdata2)
    );

    unified_mem_arbiter #(.MEM_LATENCY(3)) dut3 (
        .clk       (clk),
        .reset     (reset3),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata3),
        .if_done   (if_done3),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata3),
        .mem_done  (mem_done3),
        .stall_if  (stall_if3),
        .stall_mem (stall_mem3),
        .ram_en    (ram_en3),
        .ram_we    (ram_we3),
        .ram_addr  (ram_addr3),
        .ram_wdata (ram_wdata3),
        .ram_rdata (ram_rdata3)
    );

    // Shared RAM; read data is only valid exactly L cycles after issue.
    bit [31:0] memW  [64];
    bit        wrote [64];
    int        p2 = 0;
    int        p3 = 0;
    bit [31:0] d2 = 0;
    bit [31:0] d3 = 0;

    function automatic bit [31:0] initWord(input int idx);
        case (idx)
            1:       return 32'h8C02_0000;
            2:       return 32'h3333_3333;
            4:       return 32'h1111_1111;
            12:      return 32'h2222_2222;
            default: return 32'hA5A5_0000 | 32'(idx);
        endcase
    endfunction

    function automatic bit [31:0] readWord(input int idx);
        return wrote[idx] ? memW[idx] : initWord(idx);
    endfunction

    always @(posedge clk) begin
        if (ram_en2) begin
            if (ram_we2) begin
                memW[ram_addr2[7:2]]  <= ram_wdata2;
                wrote[ram_addr2[7:2]] <= 1'b1;
            end
            p2 <= 2;
            d2 <= readWord(int'(ram_addr2[7:2]));
        end else if (p2 != 0) begin
            p2 <= p2 - 1;
        end
        if (ram_en3) begin
            if (ram_we3) begin
                memW[ram_addr3[7:2]]  <= ram_wdata3;
                wrote[ram_addr3[7:2]] <= 1'b1;
            end
            p3 <= 3;
            d3 <= readWord(int'(ram_addr3[7:2]));
        end else if (p3 != 0) begin
            p3 <= p3 - 1;
        end
    end

    assign ram_rdata2 = (p2 == 1) ? d2 : 32'hBAD0_BAD0;
    assign ram_rdata3 = (p3 == 1) ? d3 : 32'hBAD0_BAD0;

    // MEM-stage requests must be held until mem_done.
    logic dataPend = 1'b0;
    always @(posedge clk) begin
        if (!reset2 && dataPend) begin
            assert (mem_rd | mem_wr)
            else $error("protocol: MEM request dropped before mem_done");
        end
        dataPend <= !reset2 && (mem_rd | mem_wr) && !mem_done2;
    end

    typedef struct {
        logic        ifq;
        logic [31:0] ifa;
        logic        rd;
        logic        wr;
        logic [31:0] ma;
        logic [31:0] wd;
        logic        en;
        logic        we;
        logic        ifd;
        logic        md;
        logic        sif;
        logic        smem;
        logic        ckIf;
        logic [31:0] ifr;
        logic        ckMem;
        logic [31:0] mr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic ifq, input logic [31:0] ifa,
        input logic rd, input logic wr,
        input logic [31:0] ma, input logic [31:0] wd,
        input logic en, input logic we, input logic ifd, input logic md,
        input logic sif, input logic smem,
        input logic ckIf, input logic [31:0] ifr,
        input logic ckMem, input logic [31:0] mr);
        vec_t v;
        v.ifq = ifq; v.ifa = ifa; v.rd = rd; v.wr = wr;
        v.ma = ma; v.wd = wd; v.en = en; v.we = we;
        v.ifd = ifd; v.md = md; v.sif = sif; v.smem = smem;
        v.ckIf = ckIf; v.ifr = ifr; v.ckMem = ckMem; v.mr = mr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    localparam logic [31:0] I4  = 32'h8C02_0000;
    localparam logic [31:0] I8  = 32'h3333_3333;
    localparam logic [31:0] W10 = 32'h1111_1111;
    localparam logic [31:0] W30 = 32'h2222_2222;
    localparam logic [31:0] DB  = 32'hDEAD_BEEF;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset2 = 1'b1; reset3 = 1'b1;
        if_req = 1'b0; if_addr = '0;
        mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0;

        // Fetch only
        vecs.push_back(mk(1, 32'h4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h4, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, I4, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, I4, 1, 0));
        // Simultaneous load and fetch: data wins
        vecs.push_back(mk(1, 32'h8, 1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h8, 1, 0, 32'h10, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h8, 1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h8, 1, 0, 32'h10, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, W10));
        vecs.push_back(mk(1, 32'h8, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h8, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, I8, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, I8, 1, W10));
        // Store then load, same address
        vecs.push_back(mk(0, 0, 0, 1, 32'h20, DB, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h20, DB, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h20, DB, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h20, DB, 0, 0, 0, 1, 0, 0, 0, 0, 1, W10));
        vecs.push_back(mk(0, 0, 1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h20, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h20, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, DB));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DB));
        // Load arrives during an in-flight fetch
        vecs.push_back(mk(1, 32'h4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h4, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h4, 1, 0, 32'h30, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h4, 1, 0, 32'h30, 0, 0, 0, 1, 0, 0, 1, 1, I4, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h30, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h30, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h30, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, W30));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, I4, 1, W30));
        // Flush abort, then a fresh fetch proves the FSM went idle
        vecs.push_back(mk(1, 32'h8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h8, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, I4, 0, 0));
        vecs.push_back(mk(1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h10, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, W10, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, W10, 0, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst ram_en", 32'(ram_en2), 0);
        chk("rst ram_we", 32'(ram_we2), 0);
        chk("rst if_done", 32'(if_done2), 0);
        chk("rst mem_done", 32'(mem_done2), 0);
        chk("rst ram_addr", ram_addr2, 0);
        chk("rst ram_wdata", ram_wdata2, 0);
        chk("rst if_rdata", if_rdata2, 0);
        chk("rst mem_rdata", mem_rdata2, 0);
        chk("rst3 ram_addr", ram_addr3, 0);
        chk("rst3 ram_wdata", ram_wdata3, 0);
        chk("rst3 if_rdata", if_rdata3, 0);
        chk("rst3 stall_if", 32'(stall_if3), 0);
        @(posedge clk); #1;
        reset2 = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            if_req = vecs[i].ifq; if_addr = vecs[i].ifa;
            mem_rd = vecs[i].rd; mem_wr = vecs[i].wr;
            mem_addr = vecs[i].ma; mem_wdata = vecs[i].wd;
            @(negedge clk);
            chk($sformatf("row%0d ram_en", i), 32'(ram_en2), 32'(vecs[i].en));
            chk($sformatf("row%0d ram_we", i), 32'(ram_we2), 32'(vecs[i].we));
            chk($sformatf("row%0d if_done", i), 32'(if_done2), 32'(vecs[i].ifd));
            chk($sformatf("row%0d mem_done", i), 32'(mem_done2), 32'(vecs[i].md));
            chk($sformatf("row%0d stall_if", i), 32'(stall_if2), 32'(vecs[i].sif));
            chk($sformatf("row%0d stall_mem", i), 32'(stall_mem2),
                32'(vecs[i].smem));
            if (vecs[i].ckIf)
                chk($sformatf("row%0d if_rdata", i), if_rdata2, vecs[i].ifr);
            if (vecs[i].ckMem)
                chk($sformatf("row%0d mem_rdata", i), mem_rdata2, vecs[i].mr);
        end

        // Reset in the middle of a load
        @(posedge clk); #1;
        mem_rd = 1'b1; mem_addr = 32'h10;
        @(negedge clk);
        chk("rmid stall_mem", 32'(stall_mem2), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rmid issue", 32'(ram_en2), 1);
        @(posedge clk); #1;
        reset2 = 1'b1;
        @(posedge clk); #1;
        reset2 = 1'b0; mem_rd = 1'b0; mem_addr = '0;
        @(negedge clk);
        chk("rmid ram_en", 32'(ram_en2), 0);
        chk("rmid ram_we", 32'(ram_we2), 0);
        chk("rmid if_done", 32'(if_done2), 0);
        chk("rmid mem_done", 32'(mem_done2), 0);
        chk("rmid ram_addr", ram_addr2, 0);
        chk("rmid ram_wdata", ram_wdata2, 0);
        chk("rmid if_rdata", if_rdata2, 0);
        chk("rmid mem_rdata", mem_rdata2, 0);
        @(posedge clk); #1;
        reset2 = 1'b1;
        @(negedge clk);
        chk("rmid late mem_done", 32'(mem_done2), 0);
        chk("rmid late ram_en", 32'(ram_en2), 0);

        // Load on the L=3 instance after its reset
        @(posedge clk); #1;
        reset3 = 1'b0; mem_rd = 1'b1; mem_addr = 32'h20;
        @(negedge clk);
        chk("L3 c0 stall_mem", 32'(stall_mem3), 1);
        chk("L3 c0 ram_en", 32'(ram_en3), 0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 5) mem_rd = 1'b0;
            @(negedge clk);
            chk($sformatf("L3 c%0d ram_en", k), 32'(ram_en3), 32'(k == 1));
            chk($sformatf("L3 c%0d ram_we", k), 32'(ram_we3), 0);
            chk($sformatf("L3 c%0d mem_done", k), 32'(mem_done3), 32'(k == 4));
            chk($sformatf("L3 c%0d stall_mem", k), 32'(stall_mem3), 32'(k < 4));
            chk($sformatf("L3 c%0d if_done", k), 32'(if_done3), 0);
            if (k >= 4)
                chk($sformatf("L3 c%0d mem_rdata", k), mem_rdata3, DB);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-ported unified memory between the instruction-fetch (IF) requester and the load/store (MEM-stage) requester of the pipelined MIPS core. It serialises accesses and counts the fixed memory latency. It returns read data to the winning requester and drives stall_if / stall_mem so the hazard logic freezes the PC and the pipeline registers until the access completes. It sits between the PC/IF_ID front end, the EX_MEM/MEM_WB back end and the shared RAM model.

Parameters:
ADDR_W, 32, address width (byte address, passed through unchanged)
DATA_W, 32, data word width
MEM_LATENCY, 2, cycles from RAM issue to valid ram_rdata; legal range is 1..15

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  instruction fetch request
if_addr  in  ADDR_W  fetch address (PC)
if_rdata  out  DATA_W  fetched instruction
if_done  out  1  one-cycle pulse: fetch complete
mem_rd  in  1  load request
mem_wr  in  1  store request (mem_rd and mem_wr are never both 1)
mem_addr  in  ADDR_W  load/store address (ALU result)
mem_wdata  in  DATA_W  store data
mem_rdata  out  DATA_W  load data
mem_done  out  1  one-cycle pulse: load/store complete
stall_if  out  1  freeze PC and IF_ID
stall_mem  out  1  freeze the whole pipeline behind EX_MEM
ram_en  out  1  RAM access strobe (one cycle per access)
ram_we  out  1  RAM write enable, qualified by ram_en
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid MEM_LATENCY cycles after ram_en

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- States: IDLE, DATA, INST. Down-counter cnt is 4 bits wide.
- Reset values: state=IDLE, cnt=0. ram_en, ram_we, if_done, mem_done = 0. ram_addr, ram_wdata, if_rdata, mem_rdata = 0.
- Selection is evaluated in IDLE and in any completion cycle:
  - Data wins (mem_rd or mem_wr set): next state DATA.
  - Else if if_req: next state INST.
  - Else: next state IDLE.
- Grant entry, at the state-entering edge:
  - Latch the winner's address, and mem_wdata for a store, into ram_addr/ram_wdata.
  - Load cnt with MEM_LATENCY.
- Issue cycle (first cycle in DATA or INST): ram_en=1; ram_we=1 only for a store. ram_addr/ram_wdata stay stable until the next grant.
- cnt decrements each cycle after issue. The completion cycle is cnt==0.
- Completion cycle:
  - The matching done output is 1 for exactly that cycle.
  - The matching rdata output is combinationally ram_rdata. The register captures it at the edge and holds it afterwards.
  - Writes complete after the same latency, with rdata unchanged.
- Latency: request seen in IDLE at cycle t gives issue at t+1 and done at t+1+MEM_LATENCY. A back-to-back grant issues at completion+1.
- stall_if = if_req & ~if_done.
- stall_mem = (mem_rd|mem_wr) & ~mem_done.
- Both stall outputs are combinational.
- Only one access is ever outstanding. An INST access in flight is never preempted. A data request arriving during it waits and wins the next selection.
- Flush abort: if if_req drops before the INST completion cycle, the access still runs to completion so the RAM stays in sync. In that case if_done stays 0 and if_rdata is not updated.
- A MEM-stage request must stay asserted and stable until mem_done. Dropping it is a protocol violation; the bench flags it with an assertion.
- Reset mid-access: state returns to IDLE on that edge, the in-flight access is abandoned, and no done pulse is produced.

Decomposition:
- Shared package: state encoding (ST_IDLE=2'b00, ST_DATA=2'b01, ST_INST=2'b10) and the default MEM_LATENCY constant.
- One natural sub-module, mem_latency_counter:
  - Inputs: load and value.
  - Outputs: count and zero flag.
  - The FSM, muxing and stall logic stay in unified_mem_arbiter.

Test Plan:
- Fetch only, L=2: if_req=1, if_addr=0x00000004 from cycle 0, RAM word 0x8C020000. Expect ram_en at cycle 1, if_done and if_rdata=0x8C020000 at cycle 3, stall_if=1 in cycles 0..2.
- Simultaneous: mem_rd=1 with mem_addr=0x10, plus if_req=1, at cycle 0. Expect data issue at cycle 1 and mem_done at cycle 3, then fetch issue at cycle 4 and if_done at cycle 6; stall_if held through cycle 5.
- Store then load to the same address: mem_wr, addr 0x20, wdata 0xDEADBEEF, then mem_rd 0x20. Expect ram_we=1 only in the store issue cycle and mem_rdata=0xDEADBEEF at load completion.
- Data request during an in-flight fetch (arrives one cycle after fetch issue): fetch completes unpreempted, data issues the cycle after if_done, and mem_done follows MEM_LATENCY cycles after that.
- Flush abort: if_req drops one cycle after issue. Expect no if_done, if_rdata unchanged, state back to IDLE at completion+1.
- Reset mid-access, asserted in cycle 2 of a load: the next cycle shows all outputs at reset values and no mem_done. A load requested after reset completes normally with L=3 (parameter override).
